id_ex_stage: RTL

- ID/EX pipeline boundary, directly downstream of the decode control unit.
- Registers the decoded control bundle (ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp) together with the decode-stage operands.
- Contains load-use hazard detection. On a hazard it stalls PC and IF/ID and injects a bubble.
- Also handles bubble injection on branch flush and keeps a saturating bubble counter for performance debug.

---
 rtl/riscv_pipe_pkg.sv | 25 ++
 rtl/load_use_detect.sv | 18 +
 rtl/id_ex_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: control bundle layout, ALUOp classes and width defaults.
package riscv_pipe_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int REG_W_DEF  = 5;
  localparam int CTRL_W     = 8;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // Field order matches the packed bundle {ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp}
  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection between the load in EX and the instruction in ID.
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_MemRead,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             flush,
  output logic             raw,
  output logic             hazard_stall
);

  // Both sources are compared whatever the format; a load into x0 never creates a dependency.
  assign raw = ex_MemRead && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign hazard_stall = raw && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubble injection and a saturating bubble counter.
module id_ex_stage
  import riscv_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_ALUSrc,
  input  logic              id_MemToReg,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_Branch,
  input  logic [1:0]        id_ALUOp,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [3:0]        id_funct,
  input  logic              flush,
  output logic              ex_ALUSrc,
  output logic              ex_MemToReg,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_Branch,
  output logic [1:0]        ex_ALUOp,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs1,
  output logic [REG_W-1:0]  ex_rs2,
  output logic [REG_W-1:0]  ex_rd,
  output logic [3:0]        ex_funct,
  output logic              ex_valid,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_count
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  raw;
  logic  bubble;

  load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
    .ex_MemRead   (ex_ctrl.mem_read),
    .ex_rd        (ex_rd),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .flush        (flush),
    .raw          (raw),
    .hazard_stall (hazard_stall)
  );

  assign id_ctrl = '{alu_src:    id_ALUSrc,
                     mem_to_reg: id_MemToReg,
                     reg_write:  id_RegWrite,
                     mem_read:   id_MemRead,
                     mem_write:  id_MemWrite,
                     branch:     id_Branch,
                     alu_op:     id_ALUOp};

  // Flush and raw both turn this slot into a bubble; counting it once covers the flush+raw overlap.
  assign bubble = flush || raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_ctrl      <= '0;
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_funct     <= '0;
      bubble_count <= '0;
    end else begin
      ex_ctrl     <= bubble ? '0 : id_ctrl;
      ex_valid    <= !bubble;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct    <= id_funct;
      if (bubble && (bubble_count != '1))
        bubble_count <= bubble_count + CNT_W'(1);
    end
  end

  assign ex_ALUSrc   = ex_ctrl.alu_src;
  assign ex_MemToReg = ex_ctrl.mem_to_reg;
  assign ex_RegWrite = ex_ctrl.reg_write;
  assign ex_MemRead  = ex_ctrl.mem_read;
  assign ex_MemWrite = ex_ctrl.mem_write;
  assign ex_Branch   = ex_ctrl.branch;
  assign ex_ALUOp    = ex_ctrl.alu_op;

endmodule
